// File: rtl/seq_multiplier_8bit_if.sv
// Operand/result bundle between an upstream sequencer and the 8x8 multiplier.
// Latency: n/a (wires only).
// Backpressure: ready_o gates start_i; the master must hold off until ready_o is high.
interface seq_multiplier_8bit_if;
    logic        start_i;
    logic [7:0]  multiplicand_i;
    logic [7:0]  multiplier_i;
    logic        ready_o;
    logic        done_o;
    logic [15:0] product_o;

    modport master (
        output start_i, multiplicand_i, multiplier_i,
        input  ready_o, done_o, product_o
    );

    modport slave (
        input  start_i, multiplicand_i, multiplier_i,
        output ready_o, done_o, product_o
    );
endinterface

// File: rtl/seq_multiplier_8bit.sv
// Shift-and-add unsigned 8x8->16 multiplier built on two chained 4-bit ripple adders.
// Latency: done_o/product_o 8 cycles after the accepting edge; new op every 10 cycles.
// Backpressure: start_i only sampled while ready_o=1; no queuing of requests.
module adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic w_carry;

    always_comb begin
        w_carry = i_cin;
        o_sum   = 4'h0;
        for (int i = 0; i < 4; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end
endmodule

module seq_multiplier_8bit (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    seq_multiplier_8bit_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_m;
    logic [7:0]  r_a;
    logic [7:0]  r_q;
    logic [2:0]  r_cnt;
    logic [15:0] r_product;
    logic        r_ready;
    logic        r_done;

    logic [7:0]  w_madd;
    logic [7:0]  w_sum;
    logic        w_c_lo;
    logic        w_c;
    logic [15:0] w_shift;

    // Adders stay in the path every cycle; only the addend is gated by Q[0].
    assign w_madd = r_q[0] ? r_m : 8'h00;

    adder_4bit u_add_lo (
        .i_a    (r_a[3:0]),
        .i_b    (w_madd[3:0]),
        .i_cin  (1'b0),
        .o_sum  (w_sum[3:0]),
        .o_cout (w_c_lo)
    );

    adder_4bit u_add_hi (
        .i_a    (r_a[7:4]),
        .i_b    (w_madd[7:4]),
        .i_cin  (w_c_lo),
        .o_sum  (w_sum[7:4]),
        .o_cout (w_c)
    );

    // {C, sum, Q} >> 1: the adder carry lands in A[7] so it is never dropped.
    assign w_shift = {w_c, w_sum, r_q[7:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_m       <= 8'h00;
            r_a       <= 8'h00;
            r_q       <= 8'h00;
            r_cnt     <= 3'd0;
            r_product <= 16'h0000;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_m     <= bus.multiplicand_i;
                        r_q     <= bus.multiplier_i;
                        r_a     <= 8'h00;
                        r_cnt   <= 3'd0;
                        r_ready <= 1'b0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    {r_a, r_q} <= w_shift;
                    r_cnt      <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_product <= w_shift;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o   = r_ready;
    assign bus.done_o    = r_done;
    assign bus.product_o = r_product;
endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// Self-checking bench for seq_multiplier_8bit: scoreboard of expected products,
// one task per scenario, summary line at the end.
module tb_seq_multiplier_8bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seq_multiplier_8bit_if u_if ();

    seq_multiplier_8bit dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (u_if.slave)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb[$];

    // Waits (bounded) for ready_o, then drives one start request and records the expected product.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push);
        for (int i = 0; i < 20 && !u_if.ready_o; i++) @(negedge clk);
        u_if.start_i        = 1'b1;
        u_if.multiplicand_i = a;
        u_if.multiplier_i   = b;
        if (push) sb.push_back(16'(a) * 16'(b));
    endtask

    // k = number of negedges after the drive until done_o is seen (0 = timeout);
    // busy_ok clears if ready_o was ever high while waiting.
    task automatic wait_done(output int k, output bit busy_ok);
        k = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            u_if.start_i = 1'b0;
            if (u_if.done_o) begin
                k = i;
                break;
            end
            if (u_if.ready_o) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        u_if.start_i = 1'b0;
        u_if.multiplicand_i = 8'h00;
        u_if.multiplier_i = 8'h00;
        rst_n = 1'b0;
        #12;
        checks++;
        if (u_if.ready_o !== 1'b1 || u_if.done_o !== 1'b0 || u_if.product_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_values: ready=%b done=%b product=%h, want 1 0 0000",
                     u_if.ready_o, u_if.done_o, u_if.product_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int k; bit busy_ok; logic [15:0] exp;
        issue(8'h0D, 8'h0B, 1'b1);
        wait_done(k, busy_ok);
        checks++;
        if (k !== 9) begin
            errors++;
            $display("FAIL basic_latency: done after %0d negedges, want 9", k);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL basic_busy: ready_o high during calculation");
        end
        exp = sb.pop_front();
        checks++;
        if (u_if.product_o !== exp || exp !== 16'h008F) begin
            errors++;
            $display("FAIL basic_product: got %h, want %h", u_if.product_o, exp);
        end
        @(negedge clk);
        checks++;
        if (u_if.done_o !== 1'b0 || u_if.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_after: done=%b ready=%b, want 0 1", u_if.done_o, u_if.ready_o);
        end
    endtask

    task automatic test_corners();
        logic [7:0] av[4] = '{8'hFF, 8'hFF, 8'h00, 8'h5A};
        logic [7:0] bv[4] = '{8'hFF, 8'h80, 8'hA5, 8'h00};
        logic [15:0] fixed[4] = '{16'hFE01, 16'h7F80, 16'h0000, 16'h0000};
        for (int t = 0; t < 4; t++) begin
            int k; bit busy_ok; logic [15:0] exp;
            issue(av[t], bv[t], 1'b1);
            wait_done(k, busy_ok);
            checks++;
            if (k !== 9 || !busy_ok) begin
                errors++;
                $display("FAIL corner_timing[%0d]: done after %0d busy_ok=%b, want 9 1", t, k, busy_ok);
            end
            exp = sb.pop_front();
            checks++;
            if (u_if.product_o !== exp || exp !== fixed[t]) begin
                errors++;
                $display("FAIL corner_product[%0d]: got %h, want %h", t, u_if.product_o, fixed[t]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int done_cyc[$];
        bit first = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (u_if.done_o) begin
                done_cyc.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_done: done at cycle %0d with empty scoreboard", cyc);
                end else begin
                    logic [15:0] exp = sb.pop_front();
                    if (u_if.product_o !== exp) begin
                        errors++;
                        $display("FAIL b2b_product: got %h, want %h", u_if.product_o, exp);
                    end
                end
            end
            u_if.start_i = 1'b1;
            if (u_if.ready_o) begin
                u_if.multiplicand_i = first ? 8'h03 : 8'h10;
                u_if.multiplier_i   = first ? 8'h07 : 8'h10;
                sb.push_back(16'(u_if.multiplicand_i) * 16'(u_if.multiplier_i));
                first = 1'b0;
            end else begin
                u_if.multiplicand_i = 8'($urandom);
                u_if.multiplier_i   = 8'($urandom);
            end
        end
        u_if.start_i = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            if (u_if.done_o) begin
                logic [15:0] exp = sb.pop_front();
                checks++;
                if (u_if.product_o !== exp) begin
                    errors++;
                    $display("FAIL b2b_drain_product: got %h, want %h", u_if.product_o, exp);
                end
            end
        end
        checks++;
        if (sb.size() != 0 || done_cyc.size() < 2) begin
            errors++;
            $display("FAIL b2b_count: %0d dones seen, %0d left in scoreboard, want >=2 and 0",
                     done_cyc.size(), sb.size());
            sb.delete();
        end else begin
            checks++;
            if (done_cyc[1] - done_cyc[0] !== 10 || done_cyc[0] !== 9) begin
                errors++;
                $display("FAIL b2b_spacing: dones at %0d,%0d, want 9,19", done_cyc[0], done_cyc[1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int k; bit busy_ok; logic [15:0] exp;
        int extra = 0;
        issue(8'h21, 8'h13, 1'b1);
        @(negedge clk);
        u_if.start_i = 1'b0;
        u_if.multiplicand_i = 8'hFF;
        u_if.multiplier_i = 8'hEE;
        @(negedge clk);
        @(negedge clk);
        u_if.start_i = 1'b1;
        wait_done(k, busy_ok);
        checks++;
        if (k !== 6 || !busy_ok) begin
            errors++;
            $display("FAIL ignore_timing: done after %0d more negedges busy_ok=%b, want 6 1", k, busy_ok);
        end
        exp = sb.pop_front();
        checks++;
        if (u_if.product_o !== exp) begin
            errors++;
            $display("FAIL ignore_product: got %h, want %h", u_if.product_o, exp);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (u_if.done_o) extra++;
        end
        checks++;
        if (extra != 0 || u_if.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ignore_restart: %0d extra dones, ready=%b, want 0 1", extra, u_if.ready_o);
        end
    endtask

    task automatic test_reset_mid();
        int k; bit busy_ok; logic [15:0] exp;
        int stray = 0;
        issue(8'hC8, 8'h64, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            u_if.start_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (u_if.ready_o !== 1'b1 || u_if.done_o !== 1'b0 || u_if.product_o !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_values: ready=%b done=%b product=%h, want 1 0 0000",
                     u_if.ready_o, u_if.done_o, u_if.product_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (u_if.done_o) stray++;
        end
        checks++;
        if (stray != 0 || u_if.product_o !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_no_done: %0d dones, product=%h, want 0 0000", stray, u_if.product_o);
        end
        issue(8'h02, 8'h03, 1'b1);
        wait_done(k, busy_ok);
        exp = sb.pop_front();
        checks++;
        if (k !== 9 || u_if.product_o !== exp || exp !== 16'h0006) begin
            errors++;
            $display("FAIL midreset_recover: done after %0d product=%h, want 9 0006", k, u_if.product_o);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            int k; bit busy_ok;
            logic [7:0] a = 8'($urandom);
            logic [7:0] b = 8'($urandom);
            issue(a, b, 1'b1);
            wait_done(k, busy_ok);
            checks++;
            if (k !== 9 || sb.size() == 0) begin
                errors++;
                $display("FAIL random_timing[%0d]: done after %0d, want 9", n, k);
                sb.delete();
            end else begin
                logic [15:0] exp = sb.pop_front();
                if (u_if.product_o !== exp) begin
                    errors++;
                    $display("FAIL random_product[%0d]: %h*%h got %h, want %h",
                             n, a, b, u_if.product_o, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
